// File: rtl/demux8_1to4_reg.sv
// One-to-four routing demux with a one-entry holding register per channel.
// Each channel offers its word to an independent consumer via valid/ack.
module demux8_1to4_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       valid,
    input  logic [3:0]       ack,
    output logic [7:0]       xfer_count
);

    logic [WIDTH-1:0] data_p0 [4];
    logic [3:0]       vld_p0;
    logic [7:0]       cnt_p0;

    logic             xfer;
    logic [3:0]       load;
    logic [3:0]       pop;
    logic [3:0]       vld_next;

    always_comb begin
        // A channel being drained this cycle can take a new word without a bubble
        in_ready = ~vld_p0[sel] | ack[sel];
        xfer     = in_valid & in_ready;
        load     = 4'b0000;
        if (xfer) begin
            load[sel] = 1'b1;
        end
        pop      = ack & vld_p0;
        vld_next = (vld_p0 & ~pop) | load;
    end

    // Channel holding registers: data persists after a pop, only valid clears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                data_p0[i] <= '0;
            end
            vld_p0 <= 4'b0000;
            cnt_p0 <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_p0[i] <= din;
                end
            end
            vld_p0 <= vld_next;
            if (xfer) begin
                cnt_p0 <= cnt_p0 + 8'd1;
            end
        end
    end

    assign A          = data_p0[0];
    assign B          = data_p0[1];
    assign C          = data_p0[2];
    assign D          = data_p0[3];
    assign valid      = vld_p0;
    assign xfer_count = cnt_p0;

endmodule

// File: doc/demux8_1to4_reg.md
DEMUX8_1TO4_REG -- requirements
Module: demux8_1to4_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of the input and of each output channel.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port din, input, WIDTH bits, the data word to route.
REQ-005 The block SHALL have port sel, input, 2 bits, the destination channel: 00=A, 01=B, 10=C, 11=D.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning din/sel are offered this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the selected channel can accept this cycle.
REQ-008 The block SHALL have ports A, B, C, D, output, WIDTH bits each, the channel holding registers.
REQ-009 The block SHALL have port valid, output, 4 bits, where bit i means channel i holds an undelivered word (bit0=A ... bit3=D).
REQ-010 The block SHALL have port ack, input, 4 bits, where bit i means the consumer of channel i takes its word this cycle.
REQ-011 The block SHALL have port xfer_count, output, 8 bits, the number of accepted input words, modulo 256.

Function
REQ-012 Each channel SHALL be a one-entry holding register with a valid flag.
REQ-013 in_ready SHALL be combinational and equal to ~valid[sel] | ack[sel].
REQ-014 An input transfer SHALL occur when in_valid && in_ready at a rising clk edge.
REQ-015 On transfer, channel[sel] SHALL load din and valid[sel] SHALL be 1 after that edge, giving 1-cycle latency.
REQ-016 A channel pop SHALL occur when ack[i] && valid[i] at a rising edge; valid[i] SHALL clear unless the same edge loads channel i.
REQ-017 A simultaneous pop and load of the same channel SHALL replace the data with din and leave valid[i]=1, with no bubble and no loss.
REQ-018 Simultaneous pops on any set of channels and a load on a different channel SHALL all take effect on the same edge.
REQ-019 ack[i] while valid[i]=0 SHALL be ignored, with no state change.
REQ-020 in_valid while in_ready=0 SHALL be ignored: no data change, no counter increment, and the offer is not latched.
REQ-021 Unselected channels SHALL hold their data and valid flag, and the data value SHALL persist after a pop.
REQ-022 xfer_count SHALL increment by 1 per transfer and wrap 255 -> 0.
REQ-023 The block SHALL have no X propagation: all outputs SHALL be defined from reset onward.

Reset
REQ-024 While rst=1, A/B/C/D SHALL be 0, valid SHALL be 4'b0000, and xfer_count SHALL be 0, immediately and without waiting for clk.
REQ-025 Reset asserted mid-operation SHALL discard all held words, and no transfer or pop SHALL occur on an edge where rst=1.
REQ-026 After rst is released, in_ready SHALL be 1 for every sel, and the first edge with in_valid=1 SHALL transfer.

Verification
REQ-027 Fill all four channels: sel 00..11 with din AA,55,F0,0F and ack=0 -> A=AA, B=55, C=F0, D=0F, valid=1111, xfer_count=4.
REQ-028 Backpressure: with valid[0]=1 and ack=0, offer sel=00, din=33 -> in_ready=0, A stays AA, xfer_count unchanged.
REQ-029 Same-cycle pop and load: valid[1]=1, ack=0010, sel=01, din=C3 -> B=C3 next cycle, valid[1]=1, xfer_count +1.
REQ-030 Multi-pop: ack=1101 with valid=1111 and in_valid=0 -> valid=0010 next cycle, and A/C/D data unchanged.
REQ-031 Wrap: 256 transfers alternating sel with ack held high -> xfer_count returns to 0.
REQ-032 Async reset: assert rst between clock edges with valid=1111 -> outputs and valid go to 0 before the next edge, and after release in_ready=1.
